// File: rtl/mdu_hilo_if.sv
// rtl/mdu_hilo_if.sv - EX-stage to multiply/divide unit handshake interface
//
// Signals:
//   start   EX presents a valid MDU op this cycle
//   ex_wr   EX stage advancing (low = frozen)
//   op      operation code
//   rs_val  operand A
//   rt_val  operand B
//   flush   cancel any in-flight op
//   busy    MDU op in progress
//   hi_o    committed HI register
//   lo_o    committed LO register
// Modports: master = EX side, slave = MDU side.

interface mdu_hilo_if;
  logic        start;
  logic        ex_wr;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        busy;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output start, ex_wr, op, rs_val, rt_val, flush,
    input  busy, hi_o, lo_o
  );

  modport slave (
    input  start, ex_wr, op, rs_val, rt_val, flush,
    output busy, hi_o, lo_o
  );
endinterface

// File: rtl/mdu_hilo.sv
// rtl/mdu_hilo.sv - multiply/divide unit with architectural HI/LO registers
//
// Ports:
//   clk   pipeline clock
//   rst   asynchronous active-high reset
//   mdu   mdu_hilo_if.slave: start/ex_wr/op/rs_val/rt_val/flush in,
//         busy/hi_o/lo_o out
// Parameters:
//   MUL_LAT   busy cycles for a multiply (1..4), depth of the product delay line
//   DIV_ITER  restoring-division iterations (32 for a real build)
// Optional feature macro: MDU_MADD_EN enables op 110 MADD / 111 MSUB.

module mdu_hilo #(
  parameter int MUL_LAT  = 1,
  parameter int DIV_ITER = 32
) (
  input  logic      clk,
  input  logic      rst,
  mdu_hilo_if.slave mdu
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  localparam int            CW       = 6;
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV_ITER - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [63:0]   mul_pipe_q [MUL_LAT];
  logic [63:0]   mul_pipe_d [MUL_LAT];
  logic [31:0]   quo_q, quo_d;
  logic [31:0]   rem_q, rem_d;
  logic [31:0]   dvs_q, dvs_d;
  logic          quo_neg_q, quo_neg_d;
  logic          rem_neg_q, rem_neg_d;
  logic          dz_q, dz_d;
`ifdef MDU_MADD_EN
  localparam logic [CW-1:0] MADD_LAST = CW'(MUL_LAT);
  logic          madd_q, madd_d;
  logic          msub_q, msub_d;
  logic [63:0]   sum_q, sum_d;
`endif

  logic          accept;
  logic          op_signed;
  logic [63:0]   mul_a, mul_b, mul_p, mul_res;
  logic [31:0]   rs_mag, rt_mag;
  logic [32:0]   rem_sh;
  logic          sub_ok;
  logic [31:0]   quo_fix, rem_fix;

  // A frozen EX (ex_wr=0) must not issue, or it would issue again on release.
  assign accept = mdu.start & mdu.ex_wr & ~busy_q & ~mdu.flush;

  // MULT/DIV (op[0]=0) are signed; MADD/MSUB (11x) are signed as well.
  assign op_signed = ~mdu.op[0] | (mdu.op[2] & mdu.op[1]);

  // Low 64 bits of an extended 64x64 product equal the signed/unsigned product.
  assign mul_a   = {{32{op_signed & mdu.rs_val[31]}}, mdu.rs_val};
  assign mul_b   = {{32{op_signed & mdu.rt_val[31]}}, mdu.rt_val};
  assign mul_p   = mul_a * mul_b;
  assign mul_res = mul_pipe_q[MUL_LAT-1];

  assign rs_mag = (op_signed & mdu.rs_val[31]) ? (~mdu.rs_val + 32'd1) : mdu.rs_val;
  assign rt_mag = (op_signed & mdu.rt_val[31]) ? (~mdu.rt_val + 32'd1) : mdu.rt_val;

  // One restoring step: shift the next dividend bit into the partial remainder.
  assign rem_sh = {rem_q, quo_q[31]};
  assign sub_ok = rem_sh >= {1'b0, dvs_q};

  assign quo_fix = quo_neg_q ? (~quo_q + 32'd1) : quo_q;
  assign rem_fix = rem_neg_q ? (~rem_q + 32'd1) : rem_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
`ifdef MDU_MADD_EN
    madd_d    = madd_q;
    msub_d    = msub_q;
    sum_d     = sum_q;
`endif
    // Stage 0 holds its product; later stages copy forward, so after MUL_LAT
    // edges every stage carries the same product.
    mul_pipe_d[0] = mul_pipe_q[0];
    for (int i = 1; i < MUL_LAT; i++) begin
      mul_pipe_d[i] = mul_pipe_q[i-1];
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d = '0;
`ifdef MDU_MADD_EN
          madd_d = 1'b0;
`endif
          case (mdu.op)
            3'b000, 3'b001: begin
              mul_pipe_d[0] = mul_p;
              state_d       = S_MUL;
            end
            3'b010, 3'b011: begin
              quo_d     = rs_mag;
              rem_d     = '0;
              dvs_d     = rt_mag;
              quo_neg_d = op_signed & (mdu.rs_val[31] ^ mdu.rt_val[31]);
              rem_neg_d = op_signed & mdu.rs_val[31];
              dz_d      = (mdu.rt_val == 32'd0);
              state_d   = S_DIV;
            end
            3'b100: hi_d = mdu.rs_val;
            3'b101: lo_d = mdu.rs_val;
`ifdef MDU_MADD_EN
            3'b110, 3'b111: begin
              mul_pipe_d[0] = mul_p;
              madd_d        = 1'b1;
              msub_d        = mdu.op[0];
              state_d       = S_MUL;
            end
`endif
            default: ;
          endcase
        end
      end

      S_MUL: begin
        if (mdu.flush) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
`ifdef MDU_MADD_EN
          if (madd_q) begin
            // Extra cycle: accumulate first, commit on the following edge.
            if (cnt_q == MUL_LAST) begin
              sum_d = msub_q ? ({hi_q, lo_q} - mul_res) : ({hi_q, lo_q} + mul_res);
            end else if (cnt_q == MADD_LAST) begin
              {hi_d, lo_d} = sum_q;
              state_d      = S_IDLE;
            end
          end else
`endif
          if (cnt_q == MUL_LAST) begin
            {hi_d, lo_d} = mul_res;
            state_d      = S_IDLE;
          end
        end
      end

      S_DIV: begin
        if (mdu.flush) begin
          state_d = S_IDLE;
        end else begin
          // Result of rem_sh - dvs is below dvs, so 32-bit wraparound is exact.
          rem_d = sub_ok ? (rem_sh[31:0] - dvs_q) : rem_sh[31:0];
          quo_d = {quo_q[30:0], sub_ok};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == DIV_LAST) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        // With a zero divisor every step subtracts nothing, so the remainder
        // is the dividend magnitude and the sign fix-up restores rs_val.
        if (!mdu.flush) begin
          lo_d = dz_q ? 32'hFFFF_FFFF : quo_fix;
          hi_d = rem_fix;
        end
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      for (int i = 0; i < MUL_LAT; i++) begin
        mul_pipe_q[i] <= '0;
      end
`ifdef MDU_MADD_EN
      madd_q    <= 1'b0;
      msub_q    <= 1'b0;
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
      for (int i = 0; i < MUL_LAT; i++) begin
        mul_pipe_q[i] <= mul_pipe_d[i];
      end
`ifdef MDU_MADD_EN
      madd_q    <= madd_d;
      msub_q    <= msub_d;
      sum_q     <= sum_d;
`endif
    end
  end

  assign mdu.busy = busy_q;
  assign mdu.hi_o = hi_q;
  assign mdu.lo_o = lo_q;

endmodule
